fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the five-stage RISC-V pipeline. It owns the PC and issues requests on a request/grant/response instruction-memory port. Returned words are buffered in a small FIFO and presented to decode through the IF/ID register. It consumes the decode stage's control outputs:
- `PCWrite`/`FetchWrite` for load-use stalls.
- `PCSrc`/`pc_branch` for taken-branch redirects, which flush in-flight fetches.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset.
- `FIFO_DEPTH`, 2, instruction buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `PCWrite`  in  1  0 = issue no new request this cycle.
- `FetchWrite`  in  1  0 = hold IF/ID register and do not pop FIFO.
- `PCSrc`  in  1  taken branch this cycle; redirect to `pc_branch`.
- `pc_branch`  in  32  redirect target; bits [1:0] ignored (treated as 00).
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  request word address (byte address, [1:0]=00).
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid; in order; no earlier than cycle after gnt.
- `imem_rdata`  in  32  response instruction.
- `instruction`  out  32  IF/ID instruction (`instruction_type`).
- `pc`  out  32  IF/ID PC of `instruction`.
- `instr_valid`  out  1  IF/ID holds a real instruction; 0 = bubble.

## Operation
- State: `fetch_pc`, FIFO of {pc, instr}, `outstanding` (0/1 granted request awaiting response), `drop` (discard next response), IF/ID register.
- Maximum one outstanding request.
- `pop` = `FetchWrite` & FIFO non-empty & !`PCSrc`.
- `imem_req` = !rst & !`PCSrc` & `PCWrite` & !`drop` & (!`outstanding` | `imem_rvalid`) & (fifo_count + `outstanding` − `pop` < `FIFO_DEPTH`).
- `imem_addr` = `fetch_pc`.
- A request withdrawn before grant has no effect.
- On `imem_req` & `imem_gnt`: `outstanding`←1, FIFO entry PC recorded as `fetch_pc`, `fetch_pc`←`fetch_pc`+4 (wraps modulo 2^32).
- On `imem_rvalid`:
  - If `drop`: data discarded, `drop`←0, `outstanding`←0.
  - Otherwise: {recorded pc, `imem_rdata`} pushed to FIFO; `outstanding`←0 unless a new grant occurs in the same cycle.
- IF/ID update when `FetchWrite`=1:
  - FIFO non-empty: load head, pop, `instr_valid`←1.
  - Else: `instruction`←32'h0000_0013 (NOP), `instr_valid`←0, `pc` holds.
- `FetchWrite`=0: IF/ID holds and FIFO holds; responses still push.
- Redirect (`PCSrc`=1), wins over `FetchWrite`=0 and `PCWrite`=0:
  - FIFO flushed; IF/ID loads NOP with `instr_valid`=0.
  - `fetch_pc`←{`pc_branch`[31:2],2'b00}.
  - If `outstanding` & !`imem_rvalid`: `drop`←1.
  - If `imem_rvalid` in the same cycle: response discarded, `outstanding`←0.
- Simultaneous FIFO push and pop at full: permitted, count unchanged. Push when full without pop cannot occur (issue rule).

## Timing
- Reset values:
  - `fetch_pc`=`RESET_PC`; FIFO empty; `outstanding`=0; `drop`=0.
  - `instruction`=32'h0000_0013, `pc`=0, `instr_valid`=0; `imem_req`=0.
- First request: first cycle after `rst` deasserts.
- Latency without bypass: grant cycle t, response t+k (k≥1), FIFO valid t+k+1, IF/ID output t+k+2 (if `FetchWrite`=1).
- Throughput: 1 instruction/cycle with 1-cycle memory and `FIFO_DEPTH`≥2.
- Redirect: first target request issued the cycle after `PCSrc`, or after the dropped response arrives.
- `rst` mid-operation: all state returns to reset values immediately. A response arriving after reset release, with `outstanding`=0, is ignored.

## Configuration
- `FETCH_RESP_BYPASS_EN` defined: if `imem_rvalid` & !`drop` & FIFO empty & `FetchWrite` & !`PCSrc`, the response loads IF/ID directly and skips the FIFO; IF/ID latency becomes t+k+1.
- Undefined: every response passes through the FIFO (t+k+2).

## Test plan
- Reset release, memory grants immediately, responds 1 cycle later with 0x00500093 at 0x0 and 0x00100113 at 0x4 → `imem_addr` 0x0, 0x4, 0x8 on consecutive cycles; IF/ID shows pc 0x0, then 0x4, with `instr_valid`=1; one instruction/cycle thereafter.
- Load-use stall: `FetchWrite`=`PCWrite`=0 for 1 cycle while IF/ID holds pc 0x8 → `instruction`/`pc` unchanged that cycle; no new grant accepted; pc 0xC follows next cycle, nothing lost or duplicated.
- `PCSrc`=1, `pc_branch`=0x43 while a request is outstanding → next IF/ID is NOP with `instr_valid`=0; stale response discarded; next `imem_addr`=0x40; IF/ID next valid pc 0x40.
- `PCSrc`=1 in the same cycle as `imem_rvalid` → response discarded; request for the target issues next cycle; no `drop` left set.
- Memory withholds `imem_gnt` for 3 cycles → `imem_addr` stable at 0x10; `instr_valid`=0 for those cycles; `fetch_pc` advances only on grant.
- Assert `rst` mid-stream with FIFO full → outputs immediately return to NOP/pc 0/valid 0; the first request after release is to `RESET_PC`.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/grant/response port between fetch_stage and
// the instruction memory. One request in flight at most; responses return
// in order no earlier than the cycle after the grant.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V instruction fetch. Owns the PC, issues one request at a
// time on the imem port, buffers returned words in a small FIFO and presents
// them to decode through the IF/ID register. Honours load-use stalls and
// taken-branch redirects from decode.
// Optional build macro FETCH_RESP_BYPASS_EN: a response that finds the FIFO
// empty while decode is accepting goes straight into IF/ID (one cycle sooner).
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PCWrite,
    input  logic               FetchWrite,
    input  logic               PCSrc,
    input  logic [31:0]        pc_branch,
    fetch_stage_if.master      imem,
    output logic [31:0]        instruction,
    output logic [31:0]        pc,
    output logic               instr_valid
);
    localparam int          PW  = $clog2(FIFO_DEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [31:0]   fifo_pc    [FIFO_DEPTH];
    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          outstanding;
    logic          drop;

    logic          fifo_empty;
    logic          pop;
    logic          push;
    logic          grant;
    logic          resp_live;
    logic          bypass;
    logic [CW:0]   occupancy;
    logic          unused_branch_bits;

    // Redirect targets are word aligned; the low address bits are don't-care.
    assign unused_branch_bits = ^pc_branch[1:0];
    assign imem.imem_addr     = fetch_pc;

    // Issue/accept decisions; occupancy counts the in-flight slot so a
    // response can never find the FIFO full without a matching pop.
    always_comb begin
        fifo_empty = (count == '0);
        pop        = FetchWrite & ~fifo_empty & ~PCSrc;
        resp_live  = imem.imem_rvalid & outstanding & ~drop;
`ifdef FETCH_RESP_BYPASS_EN
        bypass     = resp_live & fifo_empty & FetchWrite & ~PCSrc;
`else
        bypass     = 1'b0;
`endif
        push       = resp_live & ~PCSrc & ~bypass;
        occupancy  = {1'b0, count} + {{CW{1'b0}}, outstanding} - {{CW{1'b0}}, pop};
        imem.imem_req = ~rst & ~PCSrc & PCWrite & ~drop
                      & (~outstanding | imem.imem_rvalid)
                      & (occupancy < (CW+1)'(FIFO_DEPTH));
        grant      = imem.imem_req & imem.imem_gnt;
    end

    // PC, outstanding-request tracking and stale-response drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
        end else if (PCSrc) begin
            fetch_pc    <= {pc_branch[31:2], 2'b00};
            drop        <= outstanding & ~imem.imem_rvalid;
            outstanding <= outstanding & ~imem.imem_rvalid;
        end else begin
            if (grant) begin
                fetch_pc    <= fetch_pc + 32'd4;
                req_pc      <= fetch_pc;
                outstanding <= 1'b1;
            end else if (imem.imem_rvalid) begin
                outstanding <= 1'b0;
            end
            if (imem.imem_rvalid) begin
                drop <= 1'b0;
            end
        end
    end

    // FIFO pointers and fill count; a redirect empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (PCSrc) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= req_pc;
            fifo_instr[wr_ptr] <= imem.imem_rdata;
        end
    end

    // IF/ID register: redirect bubbles, stall holds, otherwise load head or NOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction <= NOP;
            pc          <= '0;
            instr_valid <= 1'b0;
        end else if (PCSrc) begin
            instruction <= NOP;
            instr_valid <= 1'b0;
        end else if (FetchWrite) begin
            if (!fifo_empty) begin
                instruction <= fifo_instr[rd_ptr];
                pc          <= fifo_pc[rd_ptr];
                instr_valid <= 1'b1;
            end else if (bypass) begin
                instruction <= imem.imem_rdata;
                pc          <= req_pc;
                instr_valid <= 1'b1;
            end else begin
                instruction <= NOP;
                instr_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage (default build, FIFO_DEPTH=2, RESET_PC=0).
// A small memory model grants when gnt_en is set and answers one cycle after
// the grant, unless hold_resp delays the answer. Word at address a is
// 0x00500093 at 0x0, 0x00100113 at 0x4, otherwise 0x10000000|a.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite;
    logic        FetchWrite;
    logic        PCSrc;
    logic [31:0] pc_branch;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        instr_valid;

    logic        gnt_en;
    logic        hold_resp;
    logic        pend;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PCWrite     (PCWrite),
        .FetchWrite  (FetchWrite),
        .PCSrc       (PCSrc),
        .pc_branch   (pc_branch),
        .imem        (bus.master),
        .instruction (instruction),
        .pc          (pc),
        .instr_valid (instr_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_0000: memf = 32'h0050_0093;
            32'h0000_0004: memf = 32'h0010_0113;
            default:       memf = 32'h1000_0000 | a;
        endcase
    endfunction

    assign bus.imem_gnt = gnt_en;

    always @(posedge clk) begin
        bus.imem_rvalid <= 1'b0;
        if (bus.imem_req && bus.imem_gnt) begin
            bus.imem_rdata <= memf(bus.imem_addr);
            if (hold_resp) pend <= 1'b1;
            else           bus.imem_rvalid <= 1'b1;
        end else if (pend && !hold_resp) begin
            bus.imem_rvalid <= 1'b1;
            pend            <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] epc, input logic [31:0] ein);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_pc"}, pc, epc);
        chk({tag, "_instr"}, instruction, ein);
    endtask

    initial begin
        rst = 1'b1; PCWrite = 1'b1; FetchWrite = 1'b1; PCSrc = 1'b0;
        pc_branch = '0; gnt_en = 1'b1; hold_resp = 1'b0; pend = 1'b0;
        bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        nxt(); nxt();
        chk("rst_instr", instruction, NOP);
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);

        // cycle 0: first request right after release
        rst = 1'b0; #1;
        chk("c0_req", {31'd0, bus.imem_req}, 32'd1);
        chk("c0_addr", bus.imem_addr, 32'h0);
        nxt(); chk("c1_addr", bus.imem_addr, 32'h4);
        nxt(); chk("c2_addr", bus.imem_addr, 32'h8);
        chk("c2_valid", {31'd0, instr_valid}, 32'd0);
        nxt(); chk_ifid("c3", 32'h0, 32'h0050_0093);
        nxt(); chk_ifid("c4", 32'h4, 32'h0010_0113);
        nxt(); chk_ifid("c5", 32'h8, 32'h1000_0008);

        // load-use stall for one cycle
        FetchWrite = 1'b0; PCWrite = 1'b0; #1;
        chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
        nxt(); chk_ifid("c6_hold", 32'h8, 32'h1000_0008);
        FetchWrite = 1'b1; PCWrite = 1'b1;
        nxt(); chk_ifid("c7", 32'hC, 32'h1000_000C);

        // redirect while a request is outstanding with no response yet
        hold_resp = 1'b1;
        nxt(); chk_ifid("c8", 32'h10, 32'h1000_0010);
        chk("c8_req", {31'd0, bus.imem_req}, 32'd0);
        PCSrc = 1'b1; pc_branch = 32'h43;
        nxt(); PCSrc = 1'b0;
        chk("c9_valid", {31'd0, instr_valid}, 32'd0);
        chk("c9_instr", instruction, NOP);
        hold_resp = 1'b0; #1;
        chk("c9_req_drop", {31'd0, bus.imem_req}, 32'd0);
        nxt(); chk("c10_req_drop", {31'd0, bus.imem_req}, 32'd0);
        nxt(); chk("c11_req", {31'd0, bus.imem_req}, 32'd1);
        chk("c11_addr", bus.imem_addr, 32'h40);
        nxt(); nxt();
        chk("c13_valid", {31'd0, instr_valid}, 32'd0);
        nxt(); chk_ifid("c14", 32'h40, 32'h1000_0040);

        // redirect coinciding with a response
        chk("c14_rvalid", {31'd0, bus.imem_rvalid}, 32'd1);
        PCSrc = 1'b1; pc_branch = 32'h100;
        nxt(); PCSrc = 1'b0; #1;
        chk("c15_req", {31'd0, bus.imem_req}, 32'd1);
        chk("c15_addr", bus.imem_addr, 32'h100);
        chk("c15_valid", {31'd0, instr_valid}, 32'd0);
        nxt(); nxt(); nxt(); chk_ifid("c18", 32'h100, 32'h1000_0100);

        // grant withheld for three cycles after redirect to 0x10
        PCSrc = 1'b1; pc_branch = 32'h10; gnt_en = 1'b0;
        nxt(); PCSrc = 1'b0; #1;
        chk("c19_addr", bus.imem_addr, 32'h10);
        chk("c19_req", {31'd0, bus.imem_req}, 32'd1);
        chk("c19_valid", {31'd0, instr_valid}, 32'd0);
        nxt(); chk("c20_addr", bus.imem_addr, 32'h10);
        chk("c20_valid", {31'd0, instr_valid}, 32'd0);
        nxt(); chk("c21_addr", bus.imem_addr, 32'h10);
        chk("c21_valid", {31'd0, instr_valid}, 32'd0);
        gnt_en = 1'b1;
        nxt(); chk("c22_addr", bus.imem_addr, 32'h14);
        nxt(); nxt(); chk_ifid("c24", 32'h10, 32'h1000_0010);

        // fill the FIFO, then reset mid-stream
        FetchWrite = 1'b0;
        nxt(); chk("c25_full_req", {31'd0, bus.imem_req}, 32'd0);
        chk_ifid("c25_hold", 32'h10, 32'h1000_0010);
        rst = 1'b1; #1;
        chk("mrst_instr", instruction, NOP);
        chk("mrst_pc", pc, 32'h0);
        chk("mrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("mrst_req", {31'd0, bus.imem_req}, 32'd0);
        nxt(); rst = 1'b0; FetchWrite = 1'b1; #1;
        chk("rel_req", {31'd0, bus.imem_req}, 32'd1);
        chk("rel_addr", bus.imem_addr, 32'h0);
        nxt(); nxt(); nxt(); chk_ifid("rel_a", 32'h0, 32'h0050_0093);
        nxt(); chk_ifid("rel_b", 32'h4, 32'h0010_0113);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
